// File: rtl/game_pkg.sv
// Shared types and constants for the player life manager: state encoding,
// widths, default tick counts and the registered output bundle.
package game_pkg;

    localparam int LIVES_W = 3;
    localparam int TIMER_W = 8;

    localparam int DEF_LIVES_INIT   = 3;
    localparam int DEF_DEATH_TICKS  = 16;
    localparam int DEF_INVULN_TICKS = 48;
    localparam int DEF_BLINK_DIV    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALIVE    = 3'd1,
        ST_DYING    = 3'd2,
        ST_INVULN   = 3'd3,
        ST_GAMEOVER = 3'd4
    } life_state_t;

    typedef struct packed {
        logic reimu_visible;
        logic invuln;
        logic hit_pulse;
        logic respawn;
        logic gameover;
    } life_out_t;

    // Lives never wrap below zero.
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] l);
        return (l == '0) ? '0 : l - 1'b1;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down counter with a zero flag; stops at zero until reloaded.
module tick_timer
    import game_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk22,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/reimu_life_ctrl.sv
// Player hit/life manager: accepts bullet hits, counts lives and sequences
// death, respawn, blinking invulnerability and game over. All outputs registered.
module reimu_life_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = DEF_LIVES_INIT,
    parameter int DEATH_TICKS  = DEF_DEATH_TICKS,
    parameter int INVULN_TICKS = DEF_INVULN_TICKS,
    parameter int BLINK_DIV    = DEF_BLINK_DIV
) (
    input  logic               clk22,
    input  logic               rst,
    input  logic               gamestart,
    input  logic               shot,
    input  logic               enemy_shot,
    output logic [LIVES_W-1:0] lives,
    output logic               reimu_visible,
    output logic               invuln,
    output logic               hit_pulse,
    output logic               respawn,
    output logic               gameover
);

    localparam logic [LIVES_W-1:0] LIVES_LD  = LIVES_W'(LIVES_INIT);
    localparam logic [TIMER_W-1:0] DEATH_LD  = TIMER_W'(DEATH_TICKS - 1);
    localparam logic [TIMER_W-1:0] INVULN_LD = TIMER_W'(INVULN_TICKS - 1);
    localparam logic [TIMER_W-1:0] BLINK_LD  = TIMER_W'(BLINK_DIV - 1);

    life_state_t        state, state_n;
    logic [LIVES_W-1:0] lives_q, lives_n;
    life_out_t          out_q, out_n;

    logic               hit;
    logic               tmr_clr, tmr_load, tmr_dec, tmr_zero;
    logic [TIMER_W-1:0] tmr_val;
    logic               blk_clr, blk_load, blk_dec, blk_zero;

    assign hit = shot | enemy_shot;

    // Phase timer: DYING and INVULN durations.
    tick_timer #(.W(TIMER_W)) u_phase_tmr (
        .clk22    (clk22),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Blink timer: counts down one half-period of the invulnerability blink.
    tick_timer #(.W(TIMER_W)) u_blink_tmr (
        .clk22    (clk22),
        .rst      (rst),
        .clr      (blk_clr),
        .load     (blk_load),
        .load_val (BLINK_LD),
        .dec      (blk_dec),
        .zero     (blk_zero)
    );

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            lives_q <= LIVES_LD;
            out_q   <= '0;
        end else begin
            state   <= state_n;
            lives_q <= lives_n;
            out_q   <= out_n;
        end
    end

    always_comb begin
        state_n           = state;
        lives_n           = lives_q;
        out_n             = out_q;
        out_n.hit_pulse   = 1'b0;
        out_n.respawn     = 1'b0;
        tmr_clr           = 1'b0;
        tmr_load          = 1'b0;
        tmr_val           = '0;
        tmr_dec           = 1'b0;
        blk_clr           = 1'b0;
        blk_load          = 1'b0;
        blk_dec           = 1'b0;

        if (gamestart) begin
            state_n = ST_IDLE;
            lives_n = LIVES_LD;
            out_n   = '0;
            tmr_clr = 1'b1;
            blk_clr = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_n             = ST_ALIVE;
                    out_n.reimu_visible = 1'b1;
                    out_n.invuln        = 1'b0;
                    out_n.gameover      = 1'b0;
                end
                ST_ALIVE: begin
                    if (hit) begin
                        state_n             = ST_DYING;
                        lives_n             = lives_dec(lives_q);
                        out_n.hit_pulse     = 1'b1;
                        out_n.reimu_visible = 1'b0;
                        out_n.invuln        = 1'b1;
                        tmr_load            = 1'b1;
                        tmr_val             = DEATH_LD;
                    end
                end
                ST_DYING: begin
                    if (!tmr_zero) begin
                        tmr_dec = 1'b1;
                    end else if (lives_q == '0) begin
                        state_n             = ST_GAMEOVER;
                        out_n.gameover      = 1'b1;
                        out_n.invuln        = 1'b0;
                        out_n.reimu_visible = 1'b0;
                    end else begin
                        state_n             = ST_INVULN;
                        out_n.respawn       = 1'b1;
                        out_n.reimu_visible = 1'b1;
                        tmr_load            = 1'b1;
                        tmr_val             = INVULN_LD;
                        blk_load            = 1'b1;
                    end
                end
                ST_INVULN: begin
                    if (tmr_zero) begin
                        state_n             = ST_ALIVE;
                        out_n.reimu_visible = 1'b1;
                        out_n.invuln        = 1'b0;
                    end else begin
                        tmr_dec = 1'b1;
                        // Toggle after BLINK_DIV cycles in the current phase.
                        if (blk_zero) begin
                            blk_load            = 1'b1;
                            out_n.reimu_visible = ~out_q.reimu_visible;
                        end else begin
                            blk_dec = 1'b1;
                        end
                    end
                end
                ST_GAMEOVER: begin
                    out_n.reimu_visible = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                    out_n   = '0;
                end
            endcase
        end
    end

    assign lives         = lives_q;
    assign reimu_visible = out_q.reimu_visible;
    assign invuln        = out_q.invuln;
    assign hit_pulse     = out_q.hit_pulse;
    assign respawn       = out_q.respawn;
    assign gameover      = out_q.gameover;

endmodule

// File: tb/tb_reimu_life_ctrl.sv
// Directed bench for reimu_life_ctrl: pulse events are predicted into a
// scoreboard queue and matched (kind, cycle, lives) when the DUT emits them.
module tb_reimu_life_ctrl;

    localparam int DT = 16;
    localparam int IT = 48;
    localparam int BD = 4;

    localparam int EV_HIT  = 0;
    localparam int EV_RESP = 1;
    localparam int EV_GO   = 2;

    logic       clk22 = 1'b0;
    logic       rst, gamestart, shot, enemy_shot;
    logic [2:0] lives;
    logic       reimu_visible, invuln, hit_pulse, respawn, gameover;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;
    logic go_q = 1'b0;

    typedef struct {
        int kind;
        int cyc;
        int lv;
    } ev_t;
    ev_t sb[$];

    reimu_life_ctrl dut (
        .clk22         (clk22),
        .rst           (rst),
        .gamestart     (gamestart),
        .shot          (shot),
        .enemy_shot    (enemy_shot),
        .lives         (lives),
        .reimu_visible (reimu_visible),
        .invuln        (invuln),
        .hit_pulse     (hit_pulse),
        .respawn       (respawn),
        .gameover      (gameover)
    );

    always #5 clk22 = ~clk22;
    always @(posedge clk22) ecnt <= ecnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int cyc, input int lv);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.lv   = lv;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input string tag);
        ev_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_unexpected: observed pulse at cycle %0d expected none", tag, ecnt);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_kind"},  kind,  e.kind);
            check({tag, "_cyc"},   ecnt,  e.cyc);
            check({tag, "_lives"}, lives, e.lv);
        end
    endtask

    always @(negedge clk22) begin
        if (hit_pulse)             pop_cmp(EV_HIT,  "hit");
        if (respawn)               pop_cmp(EV_RESP, "respawn");
        if (gameover && !go_q)     pop_cmp(EV_GO,   "gameover");
        go_q <= gameover;
    end

    task automatic wait_to(input int t);
        while (ecnt < t) @(negedge clk22);
    endtask

    task automatic restart();
        gamestart = 1'b1;
        @(negedge clk22);
        check("restart_lives", lives, 3);
        gamestart = 1'b0;
        @(negedge clk22);
        check("restart_vis", reimu_visible, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e, f, g, h, d;
        rst = 1'b1; gamestart = 1'b1; shot = 1'b0; enemy_shot = 1'b0;
        repeat (2) @(negedge clk22);
        check("rst_lives", lives, 3);
        check("rst_vis", reimu_visible, 0);
        check("rst_invuln", invuln, 0);
        check("rst_hit", hit_pulse, 0);
        check("rst_respawn", respawn, 0);
        check("rst_gameover", gameover, 0);

        rst = 1'b0;
        repeat (2) @(negedge clk22);
        check("idle_vis", reimu_visible, 0);
        gamestart = 1'b0;
        @(negedge clk22);
        check("start_vis", reimu_visible, 1);
        check("start_lives", lives, 3);
        check("start_invuln", invuln, 0);
        check("start_gameover", gameover, 0);

        // Single hit, full death / respawn / blink sequence.
        e = ecnt;
        shot = 1'b1;
        push(EV_HIT, e + 1, 2);
        push(EV_RESP, e + 1 + DT, 2);
        @(negedge clk22);
        shot = 1'b0;
        check("hit_vis", reimu_visible, 0);
        check("hit_invuln", invuln, 1);
        check("hit_lives", lives, 2);
        wait_to(e + 6);
        enemy_shot = 1'b1;
        @(negedge clk22);
        enemy_shot = 1'b0;
        wait_to(e + DT);
        check("dying_end_vis", reimu_visible, 0);
        for (int k = 0; k < IT; k++) begin
            wait_to(e + 1 + DT + k);
            enemy_shot = (k == 10 || k == 11);
            check($sformatf("blink_vis_%0d", k), reimu_visible, ((k / BD) % 2) == 0);
            check($sformatf("blink_inv_%0d", k), invuln, 1);
        end
        enemy_shot = 1'b0;
        wait_to(e + 1 + DT + IT);
        check("alive_vis", reimu_visible, 1);
        check("alive_invuln", invuln, 0);
        check("alive_lives", lives, 2);

        // Both hit sources held 100 cycles: exactly two hits.
        restart();
        f = ecnt;
        shot = 1'b1; enemy_shot = 1'b1;
        push(EV_HIT,  f + 1, 2);
        push(EV_RESP, f + 1 + DT, 2);
        push(EV_HIT,  f + 2 + DT + IT, 1);
        push(EV_RESP, f + 2 + 2 * DT + IT, 1);
        wait_to(f + 100);
        shot = 1'b0; enemy_shot = 1'b0;
        wait_to(f + 2 + 2 * (DT + IT));
        check("held_lives", lives, 1);
        check("held_vis", reimu_visible, 1);
        check("held_invuln", invuln, 0);

        // Three hits to game over.
        restart();
        for (int i = 0; i < 3; i++) begin
            g = ecnt;
            shot = 1'b1;
            push(EV_HIT, g + 1, 2 - i);
            push((i < 2) ? EV_RESP : EV_GO, g + 1 + DT, 2 - i);
            @(negedge clk22);
            shot = 1'b0;
            if (i < 2) wait_to(g + 1 + DT + IT);
            else       wait_to(g + 1 + DT);
        end
        check("go_flag", gameover, 1);
        check("go_vis", reimu_visible, 0);
        check("go_invuln", invuln, 0);
        check("go_lives", lives, 0);
        shot = 1'b1;
        repeat (5) @(negedge clk22);
        shot = 1'b0;
        check("go_hold", gameover, 1);
        gamestart = 1'b1;
        @(negedge clk22);
        check("go_clr_flag", gameover, 0);
        check("go_clr_lives", lives, 3);
        gamestart = 1'b0;
        @(negedge clk22);

        // Asynchronous reset in the middle of invulnerability.
        h = ecnt;
        shot = 1'b1;
        push(EV_HIT, h + 1, 2);
        push(EV_RESP, h + 1 + DT, 2);
        @(negedge clk22);
        shot = 1'b0;
        wait_to(h + 30);
        #2 rst = 1'b1;
        #1;
        check("arst_lives", lives, 3);
        check("arst_vis", reimu_visible, 0);
        check("arst_invuln", invuln, 0);
        check("arst_hit", hit_pulse, 0);
        check("arst_respawn", respawn, 0);
        check("arst_gameover", gameover, 0);
        repeat (3) @(negedge clk22);
        rst = 1'b0;
        @(negedge clk22);
        check("arst_alive_vis", reimu_visible, 1);

        // gamestart during the death animation.
        d = ecnt;
        shot = 1'b1;
        push(EV_HIT, d + 1, 2);
        @(negedge clk22);
        shot = 1'b0;
        wait_to(d + 6);
        gamestart = 1'b1;
        @(negedge clk22);
        check("gs_dying_lives", lives, 3);
        check("gs_dying_invuln", invuln, 0);
        check("gs_dying_vis", reimu_visible, 0);
        gamestart = 1'b0;
        repeat (30) @(negedge clk22);
        check("gs_dying_alive", reimu_visible, 1);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reimu_life_ctrl.md
# reimu_life_ctrl

Player hit and life manager for the shooter core. Consumes the registered hit flags from the boss and stage bullet engines, decrements lives, and sequences death, respawn, invulnerability blink and game over. Its outputs drive the sprite renderer (visibility), the player movement block (respawn) and the HUD/game-over screen. Runs on the 22-bit-divided game tick clock.

## Interface
- LIVES_INIT, 3: lives loaded at game start (1..7).
- DEATH_TICKS, 16: cycles spent in the death animation (1..255).
- INVULN_TICKS, 48: cycles of post-respawn invulnerability (1..255).
- BLINK_DIV, 4: half-period of the invulnerability blink, in cycles (1..INVULN_TICKS).

Ports:
- clk22  in  1  game tick clock.
- rst  in  1  reset; **asynchronous, active-high**.
- gamestart  in  1  title/restart level; high = game held at start (synchronous clear).
- shot  in  1  hit flag from the boss bullet engine (level, may stay high several cycles).
- enemy_shot  in  1  hit flag from the stage bullet engine (same semantics).
- lives  out  3  remaining lives.
- reimu_visible  out  1  player sprite enable.
- invuln  out  1  high while hits are ignored (DYING, INVULN).
- hit_pulse  out  1  one-cycle pulse per accepted hit.
- respawn  out  1  one-cycle pulse; movement block reloads start position.
- gameover  out  1  high in GAMEOVER.

## Operation
- States: IDLE, ALIVE, DYING, INVULN, GAMEOVER. All outputs registered.
- Reset: state=IDLE, lives=LIVES_INIT, timer=0, reimu_visible=0, invuln=0, hit_pulse=0, respawn=0, gameover=0.
- gamestart=1 in any state: next state IDLE, lives=LIVES_INIT, timer=0, pulses 0. Highest priority after rst.
- IDLE: reimu_visible=0. gamestart=0 -> ALIVE, reimu_visible=1.
- ALIVE: hit = shot | enemy_shot. hit -> DYING, hit_pulse=1, lives=lives-1 (saturate at 0), timer=DEATH_TICKS-1, reimu_visible=0, invuln=1. Both inputs high together = one hit.
- DYING: hits ignored. timer decrements each cycle; at timer==0: if lives==0 -> GAMEOVER (gameover=1, invuln=0); else -> INVULN, respawn=1, timer=INVULN_TICKS-1, reimu_visible=1, blink phase counter=0.
- INVULN: hits ignored. reimu_visible toggles every BLINK_DIV cycles (phase counter wraps at BLINK_DIV-1). At timer==0 -> ALIVE, reimu_visible=1, invuln=0.
- GAMEOVER: reimu_visible=0, holds until gamestart=1.
- Hit level still high on the first ALIVE cycle after INVULN counts as a new hit.

## Timing
- Hit sampled at edge N -> state, lives, hit_pulse, reimu_visible=0 valid after edge N (one-cycle latency from input to output).
- DYING lasts exactly DEATH_TICKS cycles; INVULN exactly INVULN_TICKS cycles.
- respawn high exactly one cycle, coincident with first INVULN cycle.
- hit_pulse high exactly one cycle per accepted hit; never in DYING/INVULN/GAMEOVER/IDLE.
- rst mid-sequence: immediate return to reset values, no pulses emitted.
- Timer 8 bits unsigned; blink counter 8 bits; lives 3 bits, never wraps below 0.

## Structure
- Shared package (game_pkg): state enum encoding, LIVES/TIMER width constants, default tick parameters.
- One sub-module: tick_timer (loadable 8-bit down counter with zero flag), reused for the blink phase counter as a second instance.

## Test plan
- rst, gamestart 1->0 -> IDLE then ALIVE next cycle, lives=3, reimu_visible=1, gameover=0.
- shot high 1 cycle in ALIVE -> hit_pulse 1 cycle, lives=2, invisible 16 cycles, respawn pulse, blink toggles every 4 cycles for 48 cycles, then ALIVE.
- shot and enemy_shot held high 100 cycles from ALIVE -> exactly two hits (cycle 0 and first ALIVE cycle after 64), lives 3->1.
- Three hits -> lives=0, after 16 DYING cycles gameover=1, no respawn; gamestart=1 -> IDLE, lives=3.
- rst asserted mid-INVULN (asynchronous, between edges) -> outputs at reset values immediately; no respawn/hit_pulse.
- gamestart pulsed during DYING -> IDLE next edge, lives=3, invuln=0.
